// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I core definitions: base opcodes, write-back source codes,
// ALU operation classes and the packed main-control word.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  // Base opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Write-back source select
  localparam logic [2:0] WB_SEL_ALU   = 3'b000;
  localparam logic [2:0] WB_SEL_LOAD  = 3'b001;
  localparam logic [2:0] WB_SEL_PC4   = 3'b010;
  localparam logic [2:0] WB_SEL_UIMM  = 3'b011;
  localparam logic [2:0] WB_SEL_AUIPC = 3'b100;

  // ALU operation class
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  // Main control word
  typedef struct packed {
    logic       reg_write;
    logic [2:0] wb_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       use_pc_as_alu_a;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
  } ctrl_t;

  // Safe default: no state is written, no memory access, no control transfer.
  localparam ctrl_t CTRL_NOP = '0;

endpackage : rv32i_pkg

// File: rtl/rv32i_ctrl_decode.sv
// ---------------------------------------------------------------------------
// rv32i_ctrl_decode
// Purely combinational opcode decoder for the RV32I main control unit.
// Ports:
//   opcode  (in,  7) : instruction bits [6:0]
//   ctrl    (out)    : decoded control word
//   illegal (out, 1) : opcode is not one of the nine supported base opcodes
// ---------------------------------------------------------------------------
module rv32i_ctrl_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_SEL_ALU;
        ctrl.alu_src   = 1'b0;
        ctrl.alu_op    = ALU_OP_RTYPE;
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_SEL_ALU;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ITYPE;
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_SEL_LOAD;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.alu_src   = 1'b0;
        ctrl.alu_op    = ALU_OP_BRANCH;
        ctrl.branch    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_SEL_PC4;
        ctrl.alu_src   = 1'b0;
        ctrl.jump      = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_SEL_PC4;
        ctrl.alu_src   = 1'b1;
        ctrl.jalr      = 1'b1;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_SEL_UIMM;
        ctrl.alu_src   = 1'b0;
      end
      OPC_AUIPC: begin
        ctrl.reg_write       = 1'b1;
        ctrl.wb_sel          = WB_SEL_AUIPC;
        ctrl.alu_src         = 1'b1;
        ctrl.use_pc_as_alu_a = 1'b1;
      end
      default: begin
        ctrl    = CTRL_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule : rv32i_ctrl_decode

// File: rtl/rv32i_decoder_controller.sv
// ---------------------------------------------------------------------------
// rv32i_decoder_controller
// Main control unit of the RV32I core. Decodes the opcode and registers the
// resulting control word; outputs are valid one cycle after sampling.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid          : opcode/funct fields valid this cycle
//   opcode/funct3/7   : instruction fields
//   out_valid         : registered control word valid
//   reg_write, wb_sel, alu_src, alu_op, use_pc_as_alu_a,
//   mem_read, mem_write, branch, jump, jalr : control word
//   illegal           : unsupported opcode
// ---------------------------------------------------------------------------
module rv32i_decoder_controller
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  output logic       reg_write,
  output logic [2:0] wb_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       use_pc_as_alu_a,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic       jalr,
  output logic       illegal
);

  // funct3/funct7 are part of the interface for the downstream ALU decode
  // but do not influence the main control word.
  logic unused_funct;
  assign unused_funct = ^{funct3, funct7};

  ctrl_t dec_ctrl;
  logic  dec_illegal;

  rv32i_ctrl_decode u_decode (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  ctrl_t ctrl_d, ctrl_q;
  logic  illegal_d, illegal_q;
  logic  valid_d, valid_q;

  // A bubble loads the all-zero word so nothing downstream writes state.
  always_comb begin
    ctrl_d    = CTRL_NOP;
    illegal_d = 1'b0;
    valid_d   = 1'b0;
    if (in_valid) begin
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_NOP;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid       = valid_q;
  assign illegal         = illegal_q;
  assign reg_write       = ctrl_q.reg_write;
  assign wb_sel          = ctrl_q.wb_sel;
  assign alu_src         = ctrl_q.alu_src;
  assign alu_op          = ctrl_q.alu_op;
  assign use_pc_as_alu_a = ctrl_q.use_pc_as_alu_a;
  assign mem_read        = ctrl_q.mem_read;
  assign mem_write       = ctrl_q.mem_write;
  assign branch          = ctrl_q.branch;
  assign jump            = ctrl_q.jump;
  assign jalr            = ctrl_q.jalr;

endmodule : rv32i_decoder_controller

// File: tb/tb_rv32i_decoder_controller.sv
// ---------------------------------------------------------------------------
// tb_rv32i_decoder_controller
// Directed-vector bench for the RV32I main control unit. Every observed word
// is {out_valid, illegal, reg_write, wb_sel[2:0], alu_src, alu_op[1:0],
// use_pc_as_alu_a, mem_read, mem_write, branch, jump, jalr}.
// ---------------------------------------------------------------------------
module tb_rv32i_decoder_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       out_valid, reg_write, alu_src, use_pc_as_alu_a;
  logic       mem_read, mem_write, branch, jump, jalr, illegal;
  logic [2:0] wb_sel;
  logic [1:0] alu_op;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rv32i_decoder_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .out_valid       (out_valid),
    .reg_write       (reg_write),
    .wb_sel          (wb_sel),
    .alu_src         (alu_src),
    .alu_op          (alu_op),
    .use_pc_as_alu_a (use_pc_as_alu_a),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .branch          (branch),
    .jump            (jump),
    .jalr            (jalr),
    .illegal         (illegal)
  );

  // Hand-computed expected words:  ov il rw wb  as ao pc mr mw br j jr
  localparam logic [14:0] E_ZERO   = 15'b0_0_0_000_0_00_0_0_0_0_0_0;
  localparam logic [14:0] E_OP     = 15'b1_0_1_000_0_10_0_0_0_0_0_0;
  localparam logic [14:0] E_OPIMM  = 15'b1_0_1_000_1_11_0_0_0_0_0_0;
  localparam logic [14:0] E_LOAD   = 15'b1_0_1_001_1_00_0_1_0_0_0_0;
  localparam logic [14:0] E_STORE  = 15'b1_0_0_000_1_00_0_0_1_0_0_0;
  localparam logic [14:0] E_BRANCH = 15'b1_0_0_000_0_01_0_0_0_1_0_0;
  localparam logic [14:0] E_JAL    = 15'b1_0_1_010_0_00_0_0_0_0_1_0;
  localparam logic [14:0] E_JALR   = 15'b1_0_1_010_1_00_0_0_0_0_0_1;
  localparam logic [14:0] E_LUI    = 15'b1_0_1_011_0_00_0_0_0_0_0_0;
  localparam logic [14:0] E_AUIPC  = 15'b1_0_1_100_1_00_1_0_0_0_0_0;
  localparam logic [14:0] E_ILL    = 15'b1_1_0_000_0_00_0_0_0_0_0_0;

  function automatic logic [14:0] observed();
    return {out_valid, illegal, reg_write, wb_sel, alu_src, alu_op,
            use_pc_as_alu_a, mem_read, mem_write, branch, jump, jalr};
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
    $display("vec %0d %s observed=%b", vectors, tag, obs);
  endtask

  // Drive one cycle's inputs, clock them in, then sample 1 ns after the edge.
  task automatic step(input logic rn, input logic v, input logic [6:0] opc,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input string tag, input logic [14:0] exp);
    rst_n    = rn;
    in_valid = v;
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opcode   = 7'b0110011;
    funct3   = 3'b000;
    funct7   = 7'b0000000;

    // Reset held with a valid OP instruction present
    step(1'b0, 1'b1, 7'b0110011, 3'b000, 7'b0000000, "reset_edge0", E_ZERO);
    step(1'b0, 1'b1, 7'b0110011, 3'b000, 7'b0000000, "reset_edge1", E_ZERO);

    // Opcode sweep; first one is accepted on the reset-release edge
    step(1'b1, 1'b1, 7'b0110011, 3'b000, 7'b0000000, "op",     E_OP);
    step(1'b1, 1'b1, 7'b0010011, 3'b000, 7'b0000000, "op_imm", E_OPIMM);
    step(1'b1, 1'b1, 7'b0000011, 3'b010, 7'b0000000, "load",   E_LOAD);
    step(1'b1, 1'b1, 7'b0100011, 3'b010, 7'b0000000, "store",  E_STORE);
    step(1'b1, 1'b1, 7'b1100011, 3'b000, 7'b0000000, "branch", E_BRANCH);
    step(1'b1, 1'b1, 7'b1101111, 3'b000, 7'b0000000, "jal",    E_JAL);
    step(1'b1, 1'b1, 7'b1100111, 3'b000, 7'b0000000, "jalr",   E_JALR);
    step(1'b1, 1'b1, 7'b0110111, 3'b000, 7'b0000000, "lui",    E_LUI);
    step(1'b1, 1'b1, 7'b0010111, 3'b000, 7'b0000000, "auipc",  E_AUIPC);

    // Registered outputs must not follow an input change mid-cycle
    opcode = 7'b0100011;
    #2;
    check("no_comb_path", E_AUIPC);

    // Unsupported opcodes
    step(1'b1, 1'b1, 7'b1111111, 3'b111, 7'b1111111, "illegal_7f",  E_ILL);
    step(1'b1, 1'b1, 7'b0000000, 3'b000, 7'b0000000, "illegal_00",  E_ILL);
    step(1'b1, 1'b1, 7'b1110011, 3'b000, 7'b0000000, "illegal_sys", E_ILL);

    // Bubble right after an illegal word clears illegal
    step(1'b1, 1'b0, 7'b1111111, 3'b000, 7'b0000000, "bubble_after_ill", E_ZERO);

    // funct independence on OP
    for (int f = 0; f < 8; f++) begin
      step(1'b1, 1'b1, 7'b0110011, 3'(f), 7'b0100000,
           $sformatf("op_funct3_%0d", f), E_OP);
    end

    // Bubble: valid LOAD, then invalid STORE must produce no mem_write
    step(1'b1, 1'b1, 7'b0000011, 3'b010, 7'b0000000, "bubble_load",  E_LOAD);
    step(1'b1, 1'b0, 7'b0100011, 3'b010, 7'b0000000, "bubble_store", E_ZERO);
    step(1'b1, 1'b1, 7'b0100011, 3'b010, 7'b0000000, "after_bubble", E_STORE);

    // Reset mid-stream: alternate LUI/BRANCH, then one reset edge
    step(1'b1, 1'b1, 7'b0110111, 3'b000, 7'b0000000, "alt_lui0",    E_LUI);
    step(1'b1, 1'b1, 7'b1100011, 3'b000, 7'b0000000, "alt_branch0", E_BRANCH);
    step(1'b1, 1'b1, 7'b0110111, 3'b000, 7'b0000000, "alt_lui1",    E_LUI);
    step(1'b1, 1'b1, 7'b1100011, 3'b000, 7'b0000000, "alt_branch1", E_BRANCH);
    step(1'b0, 1'b1, 7'b0110111, 3'b000, 7'b0000000, "mid_reset",   E_ZERO);
    step(1'b1, 1'b1, 7'b1100011, 3'b000, 7'b0000000, "resume",      E_BRANCH);
    step(1'b1, 1'b1, 7'b0110111, 3'b000, 7'b0000000, "resume_lui",  E_LUI);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rv32i_decoder_controller

// File: doc/rv32i_decoder_controller.md
# rv32i_decoder_controller

Main control unit of the RV32I core. It takes the opcode, funct3 and funct7 fields of the current instruction and produces the control word for the rest of the core: register-file write enable, write-back source select, ALU operand and operation class, memory read/write, and branch/jump flags. The control word is held in an output register, so it is valid one cycle after the fields are sampled. An `illegal` flag and a valid qualifier go alongside it.

## Interface
- No parameters.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: the opcode/funct fields are valid this cycle.
- `opcode` input 7: instruction bits [6:0].
- `funct3` input 3: instruction bits [14:12].
- `funct7` input 7: instruction bits [31:25].
- `out_valid` output 1: the registered control word is valid.
- `reg_write` output 1: write to the register file.
- `wb_sel` output 3: write-back source.
  - 000 = ALU result
  - 001 = load data
  - 010 = PC+4
  - 011 = U-immediate
  - 100 = ALU result for PC+imm (AUIPC)
- `alu_src` output 1: ALU operand B select; 0 = rs2, 1 = immediate.
- `alu_op` output 2: ALU operation class.
  - 00 = add
  - 01 = branch compare
  - 10 = R-type, decode funct3/funct7
  - 11 = I-type, decode funct3
- `use_pc_as_alu_a` output 1: ALU operand A = PC instead of rs1.
- `mem_read`, `mem_write` output 1 each: data-memory read / write strobes.
- `branch`, `jump`, `jalr` output 1 each: conditional branch, JAL, JALR.
- `illegal` output 1: the opcode is not one of the nine supported opcodes.

## Operation
The decode is combinational on `opcode` only; `funct3` and `funct7` do not affect any control output. Each opcode produces the fields below; any signal not listed is 0.
- OP 0110011: `reg_write`=1, `wb_sel`=000, `alu_src`=0, `alu_op`=10.
- OP-IMM 0010011: `reg_write`=1, `wb_sel`=000, `alu_src`=1, `alu_op`=11.
- LOAD 0000011: `reg_write`=1, `wb_sel`=001, `alu_src`=1, `alu_op`=00, `mem_read`=1.
- STORE 0100011: `reg_write`=0, `alu_src`=1, `alu_op`=00, `mem_write`=1.
- BRANCH 1100011: `reg_write`=0, `alu_src`=0, `alu_op`=01, `branch`=1.
- JAL 1101111: `reg_write`=1, `wb_sel`=010, `alu_src`=0, `jump`=1.
- JALR 1100111: `reg_write`=1, `wb_sel`=010, `alu_src`=1, `jalr`=1.
- LUI 0110111: `reg_write`=1, `wb_sel`=011, `alu_src`=0.
- AUIPC 0010111: `reg_write`=1, `wb_sel`=100, `alu_src`=1, `use_pc_as_alu_a`=1.
- Any other opcode: every control output 0 (NOP-like safe default) and `illegal`=1.

Capture rules for the output register:
- `in_valid`=1: the register loads the decoded word and `out_valid` is set to 1.
- `in_valid`=0: the register loads the all-zero word, `illegal`=0 and `out_valid`=0. A bubble never writes state.
- At most one of `branch`, `jump`, `jalr` is 1, and `mem_read` and `mem_write` are never both 1.

## Timing
- Latency is exactly 1 cycle: fields sampled at edge N appear on the outputs after edge N; there is no backpressure.
- Reset: while `rst_n`=0 at a rising edge, every output (including `out_valid` and `illegal`) becomes 0 on that edge.
- A reset edge in the same cycle as `in_valid`=1 wins and the input is dropped.
- After `rst_n` returns to 1, the first valid input is accepted on that same edge.
- Back-to-back valid inputs give one control word per cycle, with no dead cycles.
- No combinational path from any input to any output.

## Structure
- Shared core package `rv32i_pkg` holds:
  - the opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - the WB_SEL_* codes (3 bits) and ALU_OP_* codes (2 bits);
  - a packed `ctrl_t` struct carrying the ten control fields.
- One combinational sub-module, `rv32i_ctrl_decode` (opcode in, `ctrl_t` and illegal flag out).
- The top level adds the valid/bubble gating and the output register.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 and opcode 0110011. Expect all outputs 0 and `out_valid`=0 throughout.
- Sweep all nine opcodes with `in_valid`=1, `funct3`=000, `funct7`=0000000 (LOAD/STORE with `funct3`=010). One cycle later each must match its row in Operation exactly, for example:
  - AUIPC gives `reg_write`=1, `wb_sel`=100, `alu_src`=1, `alu_op`=00, `use_pc_as_alu_a`=1, everything else 0.
  - JALR gives `reg_write`=1, `wb_sel`=010, `alu_src`=1, `jalr`=1.
- Unknown opcode 1111111 with `funct3`=111, `funct7`=1111111: every control output 0, `illegal`=1, `out_valid`=1.
- funct independence: opcode 0110011 with `funct7` 0100000 and each `funct3` 000–111 gives the same word as the funct=0 case.
- Bubble: valid LOAD, then `in_valid`=0 with opcode 0100011. The second cycle shows all zeros and `out_valid`=0, with no `mem_write` pulse.
- Reset mid-stream: alternate LUI and BRANCH every cycle, then pull `rst_n` low for one edge. The next output is all zeros, and decoding resumes on the following edge.
